// File: rtl/sum_avg_pkg.sv
// Shared definitions for the sum averager: FSM state encoding and default widths.
package sum_avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

  localparam int unsigned T_WIDTH_DEF = 12;
  localparam int unsigned LOG2_N_DEF  = 2;

endpackage

// File: rtl/sum_averager.sv
// Averages windows of 2^LOG2_N unsigned samples with valid/ready on both sides.
// Define SUM_AVG_ROUND_EN for round-half-up; otherwise the average truncates.
module sum_averager
  import sum_avg_pkg::*;
#(
  parameter int unsigned T_WIDTH = T_WIDTH_DEF,
  parameter int unsigned LOG2_N  = LOG2_N_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [T_WIDTH:0]   i_sum,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [T_WIDTH:0]   o_avg,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [LOG2_N-1:0]  o_cnt
);

  localparam int unsigned W  = T_WIDTH + 1;
  localparam int unsigned AW = W + LOG2_N;

  state_e              state_q, state_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [W-1:0]        avg_q, avg_d;
  logic                valid_q, valid_d;
  logic [AW-1:0]       acc_sum;

`ifdef SUM_AVG_ROUND_EN
  // Adding half an LSB cannot overflow AW bits since acc <= N*(2^W-1).
  localparam logic [AW-1:0] RND = AW'(1) << (LOG2_N - 1);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    valid_d = valid_q;
    acc_sum = acc_q + AW'(i_sum);

    case (state_q)
      IDLE, ACCUM: begin
        if (i_valid) begin
          if (cnt_q == '1) begin
`ifdef SUM_AVG_ROUND_EN
            avg_d = W'((acc_sum + RND) >> LOG2_N);
`else
            avg_d = W'(acc_sum >> LOG2_N);
`endif
            valid_d = 1'b1;
            state_d = HOLD;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d   = acc_sum;
            cnt_d   = cnt_q + 1'b1;
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready = (state_q != HOLD);
  assign o_valid = valid_q;
  assign o_avg   = avg_q;
  assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_sum_averager.sv
// Self-checking bench for sum_averager (T_WIDTH=12, LOG2_N=2), both rounding builds.
module tb_sum_averager;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [12:0] i_sum = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [12:0] o_avg;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [1:0]  o_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [12:0] sb[$];

  always #5 i_clk = ~i_clk;

  sum_averager #(.T_WIDTH(12), .LOG2_N(2)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sum   (i_sum),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_avg   (o_avg),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_cnt   (o_cnt)
  );

  typedef struct {
    string            name;
    logic [3:0][12:0] s;
    logic [12:0]      exp;
    bit               gaps;
  } vec_t;

`ifdef SUM_AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one window; samples are presented on negedges, results checked 1 ns after posedge.
  task automatic run_window(input string name, input logic [3:0][12:0] s,
                            input logic [12:0] exp, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_sum   = s[k];
      if (k == 3) sb.push_back(exp);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      chk({name, " cnt"}, 32'(o_cnt), 32'((k + 1) % 4));
      if (k == 3) begin
        chk({name, " valid_lat"}, 32'(o_valid), 1);
        chk({name, " ready_hold"}, 32'(o_ready), 0);
      end else if (gaps) begin
        for (int g = 0; g <= k; g++) begin
          @(posedge i_clk);
          #1;
          chk({name, " gap_cnt"}, 32'(o_cnt), 32'(k + 1));
        end
      end
    end
  endtask

  task automatic collect(input string name);
    bit seen = 1'b0;
    logic [12:0] exp;
    @(negedge i_clk);
    i_ready = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (c != 0) @(negedge i_clk);
      if (o_valid) begin
        seen = 1'b1;
        if (sb.size() == 0) chk({name, " sb_empty"}, 1, 0);
        else begin
          exp = sb.pop_front();
          chk({name, " avg"}, 32'(o_avg), 32'(exp));
        end
      end
    end
    if (!seen) chk({name, " timeout"}, 0, 1);
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    chk({name, " valid_clr"}, 32'(o_valid), 0);
    chk({name, " ready_back"}, 32'(o_ready), 1);
  endtask

  vec_t vecs[6];
  logic [12:0] held;

  initial begin
    vecs[0] = '{"basic", {13'd100, 13'd90, 13'd70, 13'd20}, 13'd70, 1'b0};
    vecs[1] = '{"round", {13'd2, 13'd2, 13'd2, 13'd1}, RND ? 13'd2 : 13'd1, 1'b0};
    vecs[2] = '{"max", {13'd8191, 13'd8191, 13'd8191, 13'd8191}, 13'd8191, 1'b0};
    vecs[3] = '{"half", {13'd2, 13'd0, 13'd0, 13'd0}, RND ? 13'd1 : 13'd0, 1'b0};
    vecs[4] = '{"gaps", {13'd40, 13'd40, 13'd40, 13'd40}, 13'd40, 1'b1};
    vecs[5] = '{"mixed", {13'd3, 13'd4096, 13'd1, 13'd4095}, RND ? 13'd2049 : 13'd2048, 1'b0};

    #12;
    chk("rst valid", 32'(o_valid), 0);
    chk("rst avg", 32'(o_avg), 0);
    chk("rst cnt", 32'(o_cnt), 0);
    i_rst_n = 1'b1;
    #1;
    chk("rst ready", 32'(o_ready), 1);

    foreach (vecs[i]) begin
      run_window(vecs[i].name, vecs[i].s, vecs[i].exp, vecs[i].gaps);
      collect(vecs[i].name);
    end

    // Backpressure: result held while i_ready low and incoming samples ignored.
    run_window("bp", {13'd10, 13'd20, 13'd30, 13'd40}, 13'd25, 1'b0);
    held = sb[0];
    @(negedge i_clk);
    i_valid = 1'b1;
    i_sum   = 13'd5;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk);
      #1;
      chk("bp avg", 32'(o_avg), 32'(held));
      chk("bp valid", 32'(o_valid), 1);
      chk("bp ready", 32'(o_ready), 0);
      chk("bp cnt", 32'(o_cnt), 0);
    end
    i_valid = 1'b0;
    collect("bp");
    run_window("post_bp", {13'd6, 13'd6, 13'd6, 13'd6}, 13'd6, 1'b0);
    collect("post_bp");

    // Asynchronous reset mid-window.
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_sum   = 13'd100;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
    end
    chk("mid cnt_pre", 32'(o_cnt), 2);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid cnt_rst", 32'(o_cnt), 0);
    chk("mid valid_rst", 32'(o_valid), 0);
    #1;
    i_rst_n = 1'b1;
    run_window("after_rst", {13'd8, 13'd8, 13'd8, 13'd8}, 13'd8, 1'b0);
    collect("after_rst");

    // Reset while a result is pending discards it.
    run_window("hold_rst", {13'd50, 13'd50, 13'd50, 13'd50}, 13'd50, 1'b0);
    #2;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    chk("hold_rst valid", 32'(o_valid), 0);
    chk("hold_rst avg", 32'(o_avg), 0);
    #1;
    i_rst_n = 1'b1;
    #1;
    chk("hold_rst ready", 32'(o_ready), 1);
    run_window("final", {13'd9, 13'd7, 13'd5, 13'd3}, 13'd6, 1'b0);
    collect("final");
    chk("sb drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_averager.md
SUM_AVERAGER -- requirements
Module: sum_averager

Interface
REQ-001 SHALL have parameter T_WIDTH, default 12, operand width of the upstream adder; sample width is T_WIDTH+1.
REQ-002 SHALL have parameter LOG2_N, default 2, log2 of samples per average; legal range 1..8.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_sum  input  T_WIDTH+1  unsigned sample (adder o_sum).
REQ-006 SHALL have port i_valid  input  1  i_sum valid this cycle.
REQ-007 SHALL have port o_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port o_avg  output  T_WIDTH+1  registered average of 2^LOG2_N samples.
REQ-009 SHALL have port o_valid  output  1  o_avg valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts o_avg.
REQ-011 SHALL have port o_cnt  output  LOG2_N  samples accepted in the current window.

Function
REQ-012 SHALL run an FSM with states IDLE (acc=0, cnt=0), ACCUM (0<cnt<N), HOLD (result pending).
REQ-013 SHALL accept a sample iff i_valid && o_ready on a rising edge; o_ready SHALL be 1 in IDLE/ACCUM and 0 in HOLD, decoded from registered state.
REQ-014 SHALL hold an unsigned accumulator of T_WIDTH+1+LOG2_N bits that cannot overflow.
REQ-015 SHALL transition IDLE->ACCUM on the first accepted sample and stay in ACCUM while cnt < N-1 after acceptance.
REQ-016 SHALL on the Nth accepted sample register o_avg, assert o_valid the next cycle (latency 1 cycle), enter HOLD, and clear acc and cnt.
REQ-017 SHALL hold o_avg and o_valid stable in HOLD until o_valid && i_ready; i_valid in HOLD SHALL be ignored.
REQ-018 SHALL on output transfer deassert o_valid and go to IDLE next cycle; o_ready high that cycle.
REQ-019 SHALL tolerate i_valid gaps in ACCUM indefinitely without changing acc or cnt.
REQ-020 SHALL wrap o_cnt from N-1 to 0 on window completion.

Reset
REQ-021 SHALL on i_rst_n low immediately force state IDLE, acc 0, cnt 0, o_avg 0, o_valid 0; o_ready reads 1 once released.
REQ-022 SHALL discard any partial window or pending result when reset asserts mid-operation.

Configuration
REQ-023 SHALL with macro SUM_AVG_ROUND_EN defined compute o_avg = (acc + 2^(LOG2_N-1)) >> LOG2_N (round half up; result provably fits T_WIDTH+1 bits).
REQ-024 SHALL without SUM_AVG_ROUND_EN compute o_avg = acc >> LOG2_N (truncate).

Structure
REQ-025 SHALL take the FSM state enum (IDLE=2'b00, ACCUM=2'b01, HOLD=2'b10) and default width constants from shared package sum_avg_pkg.
REQ-026 SHALL be a single module; no sub-module is natural, as round/shift is inline combinational logic before the o_avg register.

Verification (T_WIDTH=12, LOG2_N=2)
REQ-027 SHALL check basic: samples 20,70,90,100 back-to-back -> o_valid one cycle after 4th, o_avg=70, o_cnt 1,2,3,0.
REQ-028 SHALL check rounding: samples 1,2,2,2 -> o_avg=2 with SUM_AVG_ROUND_EN, 1 without.
REQ-029 SHALL check max: four samples 8191 -> o_avg=8191 in both builds, no overflow.
REQ-030 SHALL check backpressure: i_ready low 3 cycles after o_valid with i_valid=1, i_sum=5 -> o_avg stable, o_ready=0, no sample counted; next window starts only after transfer.
REQ-031 SHALL check reset mid-window: 2 samples of 100, pulse i_rst_n low asynchronously between edges -> o_cnt=0 immediately; then 8,8,8,8 -> o_avg=8.
REQ-032 SHALL check gaps: 4 samples of 40 separated by 0–3 idle cycles -> o_avg=40, acc/cnt unchanged on idle cycles.
